// File: rtl/llc_lookup_ctrl_pkg.sv
// Shared LLC types and constants for the lookup controller.
// Victim clean-way preference is build-selected with LLC_CLEAN_VICTIM_PREF_EN.
package llc_lookup_ctrl_pkg;

  localparam int unsigned LLC_WAYS = 16;
  localparam int unsigned WAY_W    = $clog2(LLC_WAYS);
  localparam int unsigned TAG_W    = 12;

  typedef logic [WAY_W-1:0] llc_way_t;
  typedef logic [TAG_W-1:0] llc_tag_t;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    VALID    = 2'd1,
    SHARED   = 2'd2,
    MODIFIED = 2'd3
  } llc_state_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    SCAN   = 3'd2,
    VICTIM = 3'd3,
    DONE   = 3'd4
  } llc_lookup_state_t;

  // Way index successor; wraps naturally at LLC_WAYS.
  function automatic llc_way_t way_inc(input llc_way_t w);
    return w + llc_way_t'(1);
  endfunction

endpackage

// File: rtl/llc_lookup_ctrl_victim_scan.sv
// Wrapping search for the first clean way starting at the eviction pointer.
// Only instantiated when LLC_CLEAN_VICTIM_PREF_EN is defined.
module llc_victim_scan
  import llc_lookup_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                active,
  input  llc_way_t            evict_way,
  input  logic [LLC_WAYS-1:0] dirty_bits,
  output logic                done_c,
  output llc_way_t            way_c
);

  llc_way_t p;
  llc_way_t cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      cnt <= '0;
    end else if (load) begin
      p   <= evict_way;
      cnt <= '0;
    end else if (active && !done_c) begin
      p   <= way_inc(p);
      cnt <= way_inc(cnt);
    end
  end

  // All ways dirty after a full lap falls back to the eviction pointer.
  always_comb begin
    done_c = !dirty_bits[p] || (cnt == llc_way_t'(LLC_WAYS - 1));
    way_c  = dirty_bits[p] ? evict_way : p;
  end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// LLC lookup sequencer: set read, per-way scan, hit/empty/evict response.
// Define LLC_CLEAN_VICTIM_PREF_EN to prefer a clean victim via llc_victim_scan.
module llc_lookup_ctrl
  import llc_lookup_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  llc_tag_t            req_tag,
  output logic                rd_mem_en,
  output logic                look,
  input  llc_tag_t            tags_buf [LLC_WAYS],
  input  llc_state_t          states_buf [LLC_WAYS],
  input  logic [LLC_WAYS-1:0] dirty_bits_buf,
  input  llc_way_t            evict_way_buf,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output llc_way_t            rsp_way,
  output logic                rsp_hit,
  output logic                rsp_empty,
  output logic                rsp_evict,
  output logic                incr_evict_way_buf
);

  llc_lookup_state_t state;
  llc_tag_t          tag;
  llc_way_t          idx;
  logic              empty_found;
  llc_way_t          empty_way;

  logic cur_hit;
  logic cur_inv;
  logic last_way;

  always_comb begin
    cur_inv  = (states_buf[idx] == INVALID);
    cur_hit  = (tags_buf[idx] == tag) && !cur_inv;
    last_way = (idx == llc_way_t'(LLC_WAYS - 1));
  end

`ifdef LLC_CLEAN_VICTIM_PREF_EN
  logic     victim_done_c;
  llc_way_t victim_way_c;

  llc_victim_scan u_victim_scan (
    .clk        (clk),
    .rst        (rst),
    .load       (state == SCAN),
    .active     (state == VICTIM),
    .evict_way  (evict_way_buf),
    .dirty_bits (dirty_bits_buf),
    .done_c     (victim_done_c),
    .way_c      (victim_way_c)
  );
`else
  logic unused_dirty;
  assign unused_dirty = ^dirty_bits_buf;
`endif

  // The pointer advance must coincide with the handshake itself, so it is decoded.
  assign incr_evict_way_buf = !rst && rsp_valid && rsp_ready && rsp_evict;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rd_mem_en   <= 1'b0;
      look        <= 1'b0;
      tag         <= '0;
      idx         <= '0;
      empty_found <= 1'b0;
      empty_way   <= '0;
      rsp_valid   <= 1'b0;
      rsp_way     <= '0;
      rsp_hit     <= 1'b0;
      rsp_empty   <= 1'b0;
      rsp_evict   <= 1'b0;
    end else begin
      rd_mem_en <= 1'b0;
      look      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            tag       <= req_tag;
            req_ready <= 1'b0;
            rd_mem_en <= 1'b1;
            look      <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          idx         <= '0;
          empty_found <= 1'b0;
          state       <= SCAN;
        end
        SCAN: begin
          if (cur_hit) begin
            rsp_way   <= idx;
            rsp_hit   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (cur_inv && !empty_found) begin
              empty_found <= 1'b1;
              empty_way   <= idx;
            end
            if (last_way) begin
              if (empty_found || cur_inv) begin
                rsp_way   <= empty_found ? empty_way : idx;
                rsp_empty <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= DONE;
              end else begin
`ifdef LLC_CLEAN_VICTIM_PREF_EN
                state     <= VICTIM;
`else
                rsp_way   <= evict_way_buf;
                rsp_evict <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= DONE;
`endif
              end
            end else begin
              idx <= way_inc(idx);
            end
          end
        end
`ifdef LLC_CLEAN_VICTIM_PREF_EN
        VICTIM: begin
          if (victim_done_c) begin
            rsp_way   <= victim_way_c;
            rsp_evict <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_empty <= 1'b0;
            rsp_evict <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_lookup_ctrl.sv
// Directed bench for llc_lookup_ctrl; clean-victim cases run when LLC_CLEAN_VICTIM_PREF_EN is defined.
module tb_llc_lookup_ctrl;
  import llc_lookup_ctrl_pkg::*;

`ifdef LLC_CLEAN_VICTIM_PREF_EN
  localparam int VICTIM_CLEAN_EXTRA = 1;
`else
  localparam int VICTIM_CLEAN_EXTRA = 0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  llc_tag_t            req_tag;
  logic                rd_mem_en;
  logic                look;
  llc_tag_t            tags_buf [LLC_WAYS];
  llc_state_t          states_buf [LLC_WAYS];
  logic [LLC_WAYS-1:0] dirty_bits_buf;
  llc_way_t            evict_way_buf;
  logic                rsp_valid;
  logic                rsp_ready;
  llc_way_t            rsp_way;
  logic                rsp_hit;
  logic                rsp_empty;
  logic                rsp_evict;
  logic                incr_evict_way_buf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  llc_lookup_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_tag            (req_tag),
    .rd_mem_en          (rd_mem_en),
    .look               (look),
    .tags_buf           (tags_buf),
    .states_buf         (states_buf),
    .dirty_bits_buf     (dirty_bits_buf),
    .evict_way_buf      (evict_way_buf),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_way            (rsp_way),
    .rsp_hit            (rsp_hit),
    .rsp_empty          (rsp_empty),
    .rsp_evict          (rsp_evict),
    .incr_evict_way_buf (incr_evict_way_buf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // All ways VALID with tags 0..15, way 5 holding 0x1A5.
  task automatic load_set();
    for (int i = 0; i < int'(LLC_WAYS); i++) begin
      tags_buf[i]   = llc_tag_t'(i);
      states_buf[i] = VALID;
    end
    tags_buf[5]    = 12'h1A5;
    dirty_bits_buf = '0;
    evict_way_buf  = '0;
  endtask

  task automatic request(input llc_tag_t t);
    req_valid = 1'b1;
    req_tag   = t;
  endtask

  // Cycles counted from the accept cycle (0) up to the first rsp_valid cycle.
  task automatic wait_rsp(output int cyc, output int rd_cnt, output int rd_cyc, output int inc_cnt);
    cyc = 0; rd_cnt = 0; rd_cyc = -1; inc_cnt = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
      if (rd_mem_en && look) begin
        rd_cnt++;
        rd_cyc = cyc;
      end
      if (incr_evict_way_buf && !rsp_valid) inc_cnt++;
    end while (!rsp_valid && cyc < 80);
  endtask

  int cyc, rd_cnt, rd_cyc, inc_cnt;
  logic early_rsp;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_tag = '0; rsp_ready = 1'b0;
    load_set();
    tick(); tick();
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rd_mem_en", 32'(rd_mem_en), 32'd0);
    check("reset_incr", 32'(incr_evict_way_buf), 32'd0);
    rst = 1'b0;
    tick();

    // Hit in way 5
    rsp_ready = 1'b1;
    request(12'h1A5);
    wait_rsp(cyc, rd_cnt, rd_cyc, inc_cnt);
    check("hit_latency", 32'(cyc), 32'd8);
    check("hit_rd_cycle", 32'(rd_cyc), 32'd1);
    check("hit_rd_count", 32'(rd_cnt), 32'd1);
    check("hit_way", 32'(rsp_way), 32'd5);
    check("hit_flags", {29'd0, rsp_hit, rsp_empty, rsp_evict}, 32'b100);
    check("hit_incr", 32'(incr_evict_way_buf), 32'd0);
    tick();
    check("hit_back_idle", {30'd0, req_ready, rsp_valid}, 32'b10);

    // Empty: ways 3 and 9 invalid, first one wins
    states_buf[3] = INVALID;
    states_buf[9] = INVALID;
    request(12'h7FF);
    wait_rsp(cyc, rd_cnt, rd_cyc, inc_cnt);
    check("empty_latency", 32'(cyc), 32'd18);
    check("empty_way", 32'(rsp_way), 32'd3);
    check("empty_flags", {29'd0, rsp_hit, rsp_empty, rsp_evict}, 32'b010);
    check("empty_incr", 32'(incr_evict_way_buf), 32'd0);
    tick();
    check("empty_back_idle", {30'd0, req_ready, rsp_valid}, 32'b10);

    // Evict with backpressure; way 12 is clean so both builds pick 12
    load_set();
    evict_way_buf = 4'd12;
    rsp_ready = 1'b0;
    request(12'h7FF);
    wait_rsp(cyc, rd_cnt, rd_cyc, inc_cnt);
    check("evict_latency", 32'(cyc), 32'(18 + VICTIM_CLEAN_EXTRA));
    check("evict_early_incr", 32'(inc_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("evict_hold", {22'd0, rsp_valid, rsp_hit, rsp_empty, rsp_evict, incr_evict_way_buf,
                           req_ready, 4'(rsp_way)}, {22'd0, 6'b100100, 4'd12});
      if (i < 3) tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("evict_incr_handshake", 32'(incr_evict_way_buf), 32'd1);
    tick();
    check("evict_incr_after", 32'(incr_evict_way_buf), 32'd0);
    check("evict_back_idle", {30'd0, req_ready, rsp_valid}, 32'b10);

`ifdef LLC_CLEAN_VICTIM_PREF_EN
    // Clean-victim search wraps past way 15
    evict_way_buf  = 4'd14;
    dirty_bits_buf = 16'hC001;
    request(12'h7FF);
    wait_rsp(cyc, rd_cnt, rd_cyc, inc_cnt);
    check("wrap_latency", 32'(cyc), 32'd22);
    check("wrap_way", 32'(rsp_way), 32'd1);
    check("wrap_flags", {29'd0, rsp_hit, rsp_empty, rsp_evict}, 32'b001);
    check("wrap_incr", 32'(incr_evict_way_buf), 32'd1);
    tick();

    // All dirty falls back to the pointer after a full lap
    dirty_bits_buf = '1;
    request(12'h7FF);
    wait_rsp(cyc, rd_cnt, rd_cyc, inc_cnt);
    check("alldirty_latency", 32'(cyc), 32'd34);
    check("alldirty_way", 32'(rsp_way), 32'd14);
    tick();
    dirty_bits_buf = '0;
    evict_way_buf  = '0;
`endif

    // req_valid held during SCAN with a different tag must be ignored
    request(12'h002);
    tick();
    req_valid = 1'b0;
    tick();
    check("busy_req_ready", 32'(req_ready), 32'd0);
    request(12'h1A5);
    tick(); tick(); tick();
    req_valid = 1'b0;
    check("busy_latency_valid", 32'(rsp_valid), 32'd1);
    check("busy_way", 32'(rsp_way), 32'd2);
    check("busy_hit", 32'(rsp_hit), 32'd1);
    tick();
    check("busy_back_idle", {30'd0, req_ready, rsp_valid}, 32'b10);

    // Reset mid-scan at cycle 6, new request accepted at cycle 7
    request(12'h7FF);
    early_rsp = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (rsp_valid) early_rsp = 1'b1;
    end
    rst = 1'b1;
    #1;
    check("rst_incr", 32'(incr_evict_way_buf), 32'd0);
    tick();
    rst = 1'b0;
    check("rst_no_rsp", 32'(early_rsp), 32'd0);
    check("rst_idle", {29'd0, req_ready, rsp_valid, rd_mem_en}, 32'b100);
    request(12'h1A5);
    wait_rsp(cyc, rd_cnt, rd_cyc, inc_cnt);
    check("rst_reaccept_latency", 32'(cyc), 32'd8);
    check("rst_reaccept_rd", 32'(rd_cyc), 32'd1);
    check("rst_reaccept_way", 32'(rsp_way), 32'd5);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
